mmio_arbiter: RTL and testbench

//   Shares the single write-only MMIO bus (16-bit addr, 8-bit data, req/done) among NUM_REQ masters.

---
 rtl/mmio_arbiter.sv | 155 +++++++++++++++
 tb/tb_mmio_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one write-only MMIO bus among NUM_REQ masters,
// with a per-transaction timeout and a one-cycle drain that swallows trailing done pulses.
module mmio_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*8-1:0]    req_data,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_err,
    output logic [15:0]             mmio_addr,
    output logic [7:0]              mmio_data,
    output logic                    mmio_req,
    input  logic                    mmio_done,
    output logic                    busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [15:0]        mmio_addr_q, mmio_addr_d;
    logic [7:0]         mmio_data_q, mmio_data_d;
    logic               mmio_req_q, mmio_req_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic [NUM_REQ-1:0] req_err_q, req_err_d;

    logic [15:0]        addr_arr [NUM_REQ];
    logic [7:0]         data_arr [NUM_REQ];

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_after_gnt;
    int                 off;
    int                 best_off;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[16*g +: 16];
        assign data_arr[g] = req_data[8*g +: 8];
    end

    // Smallest rotational distance from rr_ptr wins, giving upward search with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        best_off   = NUM_REQ;
        off        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q)) : (i + NUM_REQ - int'(rr_ptr_q));
            if (req_valid[i] && (off < best_off)) begin
                best_off   = off;
                pick_idx   = IDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end

    assign rr_after_gnt = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        mmio_addr_d = mmio_addr_q;
        mmio_data_d = mmio_data_q;
        mmio_req_d  = 1'b0;
        busy_d      = 1'b0;
        req_done_d  = '0;
        req_err_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = ISSUE;
                    gnt_d       = pick_idx;
                    mmio_addr_d = addr_arr[pick_idx];
                    mmio_data_d = data_arr[pick_idx];
                    timer_d     = '0;
                    mmio_req_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (mmio_done) begin
                    state_d           = DRAIN;
                    req_done_d[gnt_q] = 1'b1;
                    rr_ptr_d          = rr_after_gnt;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d          = DRAIN;
                    req_err_d[gnt_q] = 1'b1;
                    rr_ptr_d         = rr_after_gnt;
                end else begin
                    timer_d    = timer_q + TMR_W'(1);
                    mmio_req_d = 1'b1;
                end
            end
            // mmio_done is deliberately ignored here: it is the slave's trailing pulse.
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            mmio_addr_q <= '0;
            mmio_data_q <= '0;
            mmio_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_done_q  <= '0;
            req_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            mmio_addr_q <= mmio_addr_d;
            mmio_data_q <= mmio_data_d;
            mmio_req_q  <= mmio_req_d;
            busy_q      <= busy_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
        end
    end

    assign mmio_addr = mmio_addr_q;
    assign mmio_data = mmio_data_q;
    assign mmio_req  = mmio_req_q;
    assign busy      = busy_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: a table of single transactions plus
// hand-written sequences for contention, timeout, trailing done, input change and async reset.
module tb_mmio_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 255;

    logic                  clock;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*8-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic [15:0]           mmio_addr;
    logic [7:0]            mmio_data;
    logic                  mmio_req;
    logic                  mmio_done;
    logic                  busy;

    int total_count = 0;
    int bad_count   = 0;

    int slave_delay = 1;
    int slave_len   = 1;
    bit slave_mute  = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          delay;
        logic [1:0]  exp_done;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        int          exp_len;
    } vec_t;

    vec_t vecs [6];

    mmio_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_done  (req_done),
        .req_err   (req_err),
        .mmio_addr (mmio_addr),
        .mmio_data (mmio_data),
        .mmio_req  (mmio_req),
        .mmio_done (mmio_done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: raises done slave_delay cycles after it first sees mmio_req, for slave_len cycles.
    initial begin
        int age;
        int left;
        age       = 0;
        left      = 0;
        mmio_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                age       = 0;
                left      = 0;
                mmio_done = 1'b0;
            end else begin
                if (mmio_req) age++;
                else age = 0;
                if (!slave_mute && mmio_req && age == slave_delay + 1) left = slave_len;
                mmio_done = (left > 0);
                if (left > 0) left--;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid   = v.valid;
        req_addr    = {v.a1, v.a0};
        req_data    = {v.d1, v.d0};
        slave_delay = v.delay;
        slave_len   = 1;
        slave_mute  = 0;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #2;
    endtask

    // Leaves the bench at +2 of an idle cycle with all requests dropped.
    task automatic doReset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stepCycle();
    endtask

    // Follows one bus transaction; returns in the DRAIN cycle, where done/err are pulsing.
    task automatic runTxn(input string name, input int exp_wait,
                          input logic [1:0] exp_done, input logic [1:0] exp_err,
                          input logic [15:0] exp_addr, input logic [7:0] exp_data,
                          input int exp_len, input int mut_at);
        int wait_n;
        int len;
        bit stable;
        wait_n = 0;
        len    = 0;
        stable = 1;
        do begin
            stepCycle();
            wait_n++;
        end while (!mmio_req && wait_n < 20);
        checkOutput({name, "_wait"}, wait_n, exp_wait);
        if (!mmio_req) return;
        while (mmio_req && len < 600) begin
            len++;
            if (mmio_addr !== exp_addr || mmio_data !== exp_data) stable = 0;
            if (len == mut_at) begin
                req_addr[31:16] = 16'hFFFF;
                req_valid[1]    = 1'b0;
            end
            stepCycle();
        end
        checkOutput({name, "_len"}, len, exp_len);
        checkOutput({name, "_bus"}, {31'd0, stable}, 32'd1);
        checkOutput({name, "_done"}, {30'd0, req_done}, {30'd0, exp_done});
        checkOutput({name, "_err"}, {30'd0, req_err}, {30'd0, exp_err});
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int extra;
        vecs[0] = '{2'b01, 16'h1000, 16'h0000, 8'h2A, 8'h00, 1, 2'b01, 16'h1000, 8'h2A, 2};
        vecs[1] = '{2'b11, 16'h2000, 16'h3000, 8'h11, 8'h22, 1, 2'b10, 16'h3000, 8'h22, 2};
        vecs[2] = '{2'b11, 16'h4004, 16'h4008, 8'h5A, 8'hA5, 1, 2'b01, 16'h4004, 8'h5A, 2};
        vecs[3] = '{2'b01, 16'hBEEF, 16'h0000, 8'hFF, 8'h00, 3, 2'b01, 16'hBEEF, 8'hFF, 4};
        vecs[4] = '{2'b10, 16'h0000, 16'h0001, 8'h00, 8'h00, 0, 2'b10, 16'h0001, 8'h00, 1};
        vecs[5] = '{2'b10, 16'h0000, 16'hFFFF, 8'h00, 8'h80, 2, 2'b10, 16'hFFFF, 8'h80, 3};

        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #3;
        checkOutput("rst_req", {31'd0, mmio_req}, 32'd0);
        checkOutput("rst_addr", {16'd0, mmio_addr}, 32'd0);
        checkOutput("rst_data", {24'd0, mmio_data}, 32'd0);
        checkOutput("rst_done", {30'd0, req_done}, 32'd0);
        checkOutput("rst_err", {30'd0, req_err}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stepCycle();

        // Table: each vector starts from idle; round-robin pointer carries across vectors.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            runTxn($sformatf("vec%0d", i), 1, vecs[i].exp_done, 2'b00,
                   vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_len, -1);
            req_valid = '0;
            stepCycle();
            checkOutput($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
        end

        // Contention: both masters held valid from reset alternate 0,1,0,1.
        doReset();
        req_addr    = {16'h2000, 16'h1000};
        req_data    = {8'h02, 8'h01};
        slave_delay = 1;
        req_valid   = 2'b11;
        runTxn("cont0", 1, 2'b01, 2'b00, 16'h1000, 8'h01, 2, -1);
        runTxn("cont1", 2, 2'b10, 2'b00, 16'h2000, 8'h02, 2, -1);
        runTxn("cont2", 2, 2'b01, 2'b00, 16'h1000, 8'h01, 2, -1);
        runTxn("cont3", 2, 2'b10, 2'b00, 16'h2000, 8'h02, 2, -1);
        req_valid = '0;

        // Timeout on master 0, then master 1 proceeds normally.
        doReset();
        req_addr   = {16'h3333, 16'h5555};
        req_data   = {8'h33, 8'h55};
        slave_mute = 1;
        req_valid  = 2'b11;
        runTxn("tmo", 1, 2'b00, 2'b01, 16'h5555, 8'h55, TIMEOUT_CYCLES, -1);
        slave_mute = 0;
        req_valid  = 2'b10;
        runTxn("tmo_next", 2, 2'b10, 2'b00, 16'h3333, 8'h33, 2, -1);
        req_valid = '0;

        // Trailing done: second done pulse lands in DRAIN and must not produce another ack.
        doReset();
        req_addr  = {16'h0000, 16'h0C00};
        req_data  = {8'h00, 8'h7E};
        slave_len = 2;
        req_valid = 2'b01;
        runTxn("trail", 1, 2'b01, 2'b00, 16'h0C00, 8'h7E, 2, -1);
        req_valid = '0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            stepCycle();
            if (req_done != 2'b00 || req_err != 2'b00 || mmio_req) extra++;
        end
        checkOutput("trail_extra", extra, 0);
        slave_len = 1;

        // Input change mid-ISSUE: latched address holds and the ack still arrives.
        doReset();
        req_addr    = {16'h1234, 16'h0000};
        req_data    = {8'h77, 8'h00};
        slave_delay = 10;
        req_valid   = 2'b10;
        runTxn("chg", 1, 2'b10, 2'b00, 16'h1234, 8'h77, 11, 2);
        req_valid = '0;

        // Async reset mid-ISSUE: grant to master 1 is lost, master 0 wins after release.
        doReset();
        req_addr    = {16'h2222, 16'h1111};
        req_data    = {8'h22, 8'h11};
        slave_delay = 1;
        req_valid   = 2'b01;
        runTxn("pre", 1, 2'b01, 2'b00, 16'h1111, 8'h11, 2, -1);
        req_valid = '0;
        stepCycle();
        slave_delay = 10;
        req_valid   = 2'b11;
        stepCycle();
        checkOutput("ar_gnt1", {16'd0, mmio_addr}, 32'h2222);
        stepCycle();
        stepCycle();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("ar_req", {31'd0, mmio_req}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_done", {28'd0, req_done, req_err}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stepCycle();
        checkOutput("ar_regrant_req", {31'd0, mmio_req}, 32'd1);
        checkOutput("ar_regrant_addr", {16'd0, mmio_addr}, 32'h1111);
        req_valid = '0;
        repeat (15) stepCycle();

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
